e_mdu: RTL and testbench

Multi-cycle multiply/divide unit for the E stage of the five-stage pipelined MIPS core. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU with fixed latencies. It exposes `busy` so the hazard unit can stall, and produces the `MDUAns` value that travels E→M→W for MFHI/MFLO.

---
 rtl/e_mdu_pkg.sv | 28 ++
 rtl/e_mdu_if.sv | 21 ++
 rtl/e_mdu.sv | 128 ++++++++++++
 tb/tb_e_mdu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings (also used by the controller
// decoder), default latencies and the controller state type.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Signed flavours sign-extend their operands, unsigned ones zero-extend.
    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU bus: issue request from the controller plus HI/LO results.
interface e_mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUAns;

    modport master (
        output start, op, A, B,
        input  busy, HI, LO, MDUAns
    );

    modport slave (
        input  start, op, A, B,
        output busy, HI, LO, MDUAns
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Owns HI/LO, runs MULT/MULTU/DIV/DIVU with a
// fixed busy window, and serves MFHI/MFLO combinationally through MDUAns.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave bus
);

    mdu_state_t         state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [31:0]        hi, hi_nxt;
    logic [31:0]        lo, lo_nxt;
    logic [31:0]        p_hi, p_hi_nxt;
    logic [31:0]        p_lo, p_lo_nxt;
    logic               p_wr, p_wr_nxt;

    logic signed [32:0] a_ext, b_ext, b_div;
    logic signed [65:0] prod;
    logic signed [32:0] quot, rem;
    logic               div_zero;
    logic               unused_bits;

    // Operand extension and the single-cycle arithmetic feeding the pending regs.
    always_comb begin
        a_ext    = op_is_signed(bus.op) ? {bus.A[31], bus.A} : {1'b0, bus.A};
        b_ext    = op_is_signed(bus.op) ? {bus.B[31], bus.B} : {1'b0, bus.B};
        div_zero = (bus.B == 32'd0);
        // Substitute a harmless divisor so the divider never sees zero;
        // the result is discarded via p_wr in that case anyway.
        b_div    = div_zero ? 33'sd1 : b_ext;
        prod     = a_ext * b_ext;
        // 33-bit signed division makes 0x80000000 / -1 come out as +2^31,
        // whose low 32 bits are the required 0x80000000 with remainder 0.
        quot     = a_ext / b_div;
        rem      = a_ext % b_div;
    end

    assign unused_bits = ^{prod[65:64], quot[32], rem[32]};

    // Next-state, counter and HI/LO/pending update logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        p_hi_nxt  = p_hi;
        p_lo_nxt  = p_lo;
        p_wr_nxt  = p_wr;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MDU_MULT, MDU_MULTU: begin
                            p_hi_nxt  = prod[63:32];
                            p_lo_nxt  = prod[31:0];
                            p_wr_nxt  = 1'b1;
                            cnt_nxt   = 4'(MULT_CYCLES);
                            state_nxt = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            p_hi_nxt  = rem[31:0];
                            p_lo_nxt  = quot[31:0];
                            p_wr_nxt  = !div_zero;
                            cnt_nxt   = 4'(DIV_CYCLES);
                            state_nxt = ST_RUN;
                        end
                        MDU_MTHI: hi_nxt = bus.A;
                        MDU_MTLO: lo_nxt = bus.A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // New requests are ignored here; the hazard unit stalls them.
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (p_wr) begin
                        hi_nxt = p_hi;
                        lo_nxt = p_lo;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counter, architectural and pending registers; reset drops any
    // in-flight result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            p_hi  <= p_hi_nxt;
            p_lo  <= p_lo_nxt;
            p_wr  <= p_wr_nxt;
        end
    end

    // MFHI/MFLO read path, zero latency.
    always_comb begin
        bus.MDUAns = 32'd0;
        if (bus.op == MDU_MFHI)
            bus.MDUAns = hi;
        else if (bus.op == MDU_MFLO)
            bus.MDUAns = lo;
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: reference model results are queued at issue
// and compared against HI/LO when the busy window closes.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    e_mdu_if bus ();

    e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo as the architecture would.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        case (o)
            MDU_MULT: begin
                sp = longint'(sa) * longint'(sbv);
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end
            MDU_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    m_lo = sa / sbv; m_hi = sa % sbv;
                end
            end
            MDU_DIVU: begin
                if (b != 32'd0) begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_reads(input string tag);
        exp_t e;
        e.hi = m_hi; e.lo = m_lo;
        bus.op = MDU_MFHI; #1 chk({tag, "_mfhi"}, bus.MDUAns, e.hi);
        bus.op = MDU_MFLO; #1 chk({tag, "_mflo"}, bus.MDUAns, e.lo);
        bus.op = MDU_NONE; #1 chk({tag, "_none"}, bus.MDUAns, 32'd0);
    endtask

    // Count busy cycles from the current (first post-issue) cycle, bounded.
    task automatic wait_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b, input int n);
        exp_t e;
        int   c;
        model(o, a, b);
        e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        wait_busy(c);
        chk({tag, "_busy_len"}, 32'(c), 32'(n));
        e = sb.pop_front();
        chk({tag, "_hi"}, bus.HI, e.hi);
        chk({tag, "_lo"}, bus.LO, e.lo);
    endtask

    task automatic do_mt(input string tag, input logic [3:0] o, input logic [31:0] a);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = 32'd0;
        if (o == MDU_MTHI) m_hi = a; else m_lo = a;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hi"}, bus.HI, m_hi);
        chk({tag, "_lo"}, bus.LO, m_lo);
    endtask

    initial begin
        int   c;
        exp_t e;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = MDU_MFHI;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ans", bus.MDUAns, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_ans_rel", bus.MDUAns, 32'd0);
        bus.op = MDU_NONE;

        do_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, NM);
        chk("mult_hi_k", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo_k", bus.LO, 32'hFFFF_FFFA);
        do_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, NM);
        chk("multu_hi_k", bus.HI, 32'h0000_0002);
        chk("multu_lo_k", bus.LO, 32'hFFFF_FFFA);
        check_reads("multu");

        do_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, ND);
        chk("div_hi_k", bus.HI, 32'hFFFF_FFFF);
        chk("div_lo_k", bus.LO, 32'hFFFF_FFFD);
        do_op("divu", MDU_DIVU, 32'd7, 32'd2, ND);
        chk("divu_hi_k", bus.HI, 32'd1);
        chk("divu_lo_k", bus.LO, 32'd3);

        do_mt("mthi", MDU_MTHI, 32'h1234);
        do_mt("mtlo", MDU_MTLO, 32'h5678);
        do_op("div0", MDU_DIV, 32'd5, 32'd0, ND);
        chk("div0_hi_k", bus.HI, 32'h1234);
        chk("div0_lo_k", bus.LO, 32'h5678);
        do_op("divu0", MDU_DIVU, 32'd5, 32'd0, ND);
        do_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ND);
        chk("divovf_hi_k", bus.HI, 32'd0);
        chk("divovf_lo_k", bus.LO, 32'h8000_0000);

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = 4'($urandom_range(1, 4));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_op("rand", o, a, b, (o == MDU_MULT || o == MDU_MULTU) ? NM : ND);
        end
        check_reads("rand");

        // A DIV pulsed during a MULT's busy window must be dropped.
        model(MDU_MULT, 32'd2, 32'd3);
        e.hi = m_hi; e.lo = m_lo;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULT; bus.A = 32'd2; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        chk("sib_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_DIV; bus.A = 32'd9; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        wait_busy(c);
        chk("sib_busy_len", 32'(c + 2), 32'(NM));
        e = sb.pop_front();
        chk("sib_hi", bus.HI, e.hi);
        chk("sib_lo", bus.LO, e.lo);
        bus.op = MDU_MFLO;
        #1 chk("sib_mflo", bus.MDUAns, 32'd6);
        bus.op = MDU_NONE;

        // Reset in the middle of a DIV: cleared at once, no late commit.
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_DIV; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        repeat (3) @(negedge clk);
        chk("rmid_busy_pre", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_hi", bus.HI, 32'd0);
        chk("rmid_lo", bus.LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (15) begin
            @(negedge clk);
            chk("rmid_nolate", bus.HI | bus.LO | 32'(bus.busy), 32'd0);
        end

        do_op("post", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, NM);
        check_reads("post");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
